// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, branch
// classification and the 2-bit saturating predictor counter.
package fetch_pkg;

   localparam logic [5:0] OPC_BEQ  = 6'h13;
   localparam logic [5:0] OPC_BNE  = 6'h14;
   localparam logic [5:0] OPC_BLT  = 6'h15;
   localparam logic [5:0] OPC_BGE  = 6'h16;
   localparam logic [5:0] OPC_BLTU = 6'h17;
   localparam logic [5:0] OPC_BGEU = 6'h18;
   localparam logic [5:0] OPC_BGTZ = 6'h19;
   localparam logic [5:0] OPC_HALT = 6'h31;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t SNT = 2'b00;
   localparam bht_ctr_t WNT = 2'b01;
   localparam bht_ctr_t WT  = 2'b10;
   localparam bht_ctr_t ST  = 2'b11;

   function automatic logic is_cond_branch(input logic [5:0] opcode);
      return (opcode >= OPC_BEQ) && (opcode <= OPC_BGTZ);
   endfunction

   function automatic bht_ctr_t ctr_step(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t res;
      res = ctr;
      if (taken) begin
         if (ctr != ST) res = ctr + 2'd1;
      end else begin
         if (ctr != SNT) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fetch_unit_bht.sv
// Branch history table: one 2-bit saturating counter per entry, read
// combinationally, trained on the clock edge, cleared asynchronously.
module bht
   import fetch_pkg::*;
#(
   parameter int       ENTRIES = 64,
   parameter bht_ctr_t INIT    = WNT,
   localparam int      IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_ctr_t         rd_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   bht_ctr_t ctr_arr [ENTRIES];

   // Every counter must clear without a clock edge, so the table is kept
   // in individual flops rather than a RAM array.
   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
         bht_ctr_t ctr_q;
         bht_ctr_t ctr_d;

         always_comb begin
            ctr_d = ctr_q;
            if (wr_en && (wr_idx == IDX_W'(gi))) ctr_d = ctr_step(ctr_q, wr_taken);
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) ctr_q <= INIT;
            else      ctr_q <= ctr_d;
         end

         assign ctr_arr[gi] = ctr_q;
      end
   endgenerate

   // Reads see the pre-update value when the same index is written this cycle.
   assign rd_ctr = ctr_arr[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC priority mux, branch/halt
// decode and BHT-based prediction of conditional branch targets.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int         PC_W        = 32,
   parameter int         IMEM_AW     = 10,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] BHT_INIT    = 2'b01
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_addr,
   input  logic               stall,
   input  logic               switch_program,
   input  logic [PC_W-1:0]    switch_pc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               upd_valid,
   input  logic [PC_W-1:0]    upd_pc,
   input  logic               upd_taken,
   output logic [31:0]        instr,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_1,
   output logic               pred_taken,
   output logic               halt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] target;
   logic [5:0]      opcode;
   logic            is_branch;
   bht_ctr_t        rd_ctr;
   logic            unused_upd_hi;

   assign unused_upd_hi = ^upd_pc[PC_W-1:IDX_W];

   assign imem_addr = pc_q[IMEM_AW-1:0];
   assign instr     = imem_rdata;
   assign opcode    = imem_rdata[31:26];
   assign is_branch = is_cond_branch(opcode);
   assign halt      = (opcode == OPC_HALT);
   assign pc_out    = pc_q;
   assign pc_1      = pc_q + PC_W'(1);
   assign target    = pc_1 + {{(PC_W-16){imem_rdata[15]}}, imem_rdata[15:0]};

   bht #(
      .ENTRIES (BHT_ENTRIES),
      .INIT    (BHT_INIT)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (pc_q[IDX_W-1:0]),
      .rd_ctr   (rd_ctr),
      .wr_en    (upd_valid),
      .wr_idx   (upd_pc[IDX_W-1:0]),
      .wr_taken (upd_taken)
   );

   assign pred_taken = is_branch && rd_ctr[1];

   // Stall beats redirect; EX keeps redirect asserted until the stall clears.
   always_comb begin
      pc_d = pc_1;
      if (switch_program)          pc_d = switch_pc;
      else if (stall)              pc_d = pc_q;
      else if (halt && !redirect)  pc_d = pc_q;
      else if (redirect)           pc_d = redirect_addr;
      else if (pred_taken)         pc_d = target;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= '0;
      else      pc_q <= pc_d;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the driver queues the expected fetch state
// each cycle, and a monitor compares it on the falling edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        stall;
   logic        switch_program;
   logic [31:0] switch_pc;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic [31:0] pc_1;
   logic        pred_taken;
   logic        halt;

   logic [31:0] imem [1024];

   logic [33:0] exp_q [$];
   string       tag_q [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem[imem_addr];

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect       (redirect),
      .redirect_addr  (redirect_addr),
      .stall          (stall),
      .switch_program (switch_program),
      .switch_pc      (switch_pc),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .instr          (instr),
      .pc_out         (pc_out),
      .pc_1           (pc_1),
      .pred_taken     (pred_taken),
      .halt           (halt)
   );

   task automatic chk(input string tag, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
      end
   endtask

   // Monitor: one expected fetch state per cycle, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            logic [33:0] e;
            logic [31:0] e_pc;
            logic [31:0] e_pc1;
            logic [9:0]  e_addr;
            string       t;
            e      = exp_q.pop_front();
            t      = tag_q.pop_front();
            e_pc   = e[33:2];
            e_pc1  = e_pc + 32'd1;
            e_addr = e_pc[9:0];
            chk(t, "pc_out", pc_out, e_pc);
            chk(t, "pc_1", pc_1, e_pc1);
            chk(t, "imem_addr", {22'd0, imem_addr}, {22'd0, e_addr});
            chk(t, "instr", instr, imem[e_addr]);
            chk(t, "pred_taken", {31'd0, pred_taken}, {31'd0, e[1]});
            chk(t, "halt", {31'd0, halt}, {31'd0, e[0]});
            $display("txn %-20s pc=%h pred=%b halt=%b", t, pc_out, pred_taken, halt);
         end
      end
   end

   task automatic clear_inputs();
      redirect       = 1'b0;
      stall          = 1'b0;
      switch_program = 1'b0;
      upd_valid      = 1'b0;
      upd_taken      = 1'b0;
   endtask

   // Expectation for the state after this edge; the caller then drives the
   // inputs that decide the next edge.
   task automatic step(input logic [31:0] e_pc, input logic e_pred, input logic e_halt,
                       input string tag);
      @(posedge clk);
      #1;
      exp_q.push_back({e_pc, e_pred, e_halt});
      tag_q.push_back(tag);
      clear_inputs();
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken);
      upd_valid = 1'b1;
      upd_pc    = pc;
      upd_taken = taken;
   endtask

   task automatic redir(input logic [31:0] addr);
      redirect      = 1'b1;
      redirect_addr = addr;
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: got no finish expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
      imem[5] = 32'h4C00_FFFC;   // BEQ, offset -4: target 2
      imem[8] = 32'hC400_0000;   // HALT
      rst           = 1'b0;
      redirect_addr = 32'h0;
      switch_pc     = 32'h0;
      upd_pc        = 32'h0;
      clear_inputs();

      step(32'd0, 1'b0, 1'b0, "reset");
      rst = 1'b1;
      step(32'd1, 1'b0, 1'b0, "run1");
      step(32'd2, 1'b0, 1'b0, "run2");
      step(32'd3, 1'b0, 1'b0, "run3");
      step(32'd4, 1'b0, 1'b0, "run4");
      step(32'd5, 1'b0, 1'b0, "br_cold");        upd(32'd5, 1'b1);
      step(32'd6, 1'b0, 1'b0, "train1");         upd(32'd5, 1'b1);
      step(32'd7, 1'b0, 1'b0, "pre_halt");
      for (int i = 0; i < 10; i++) step(32'd8, 1'b0, 1'b1, "halt_hold");
      redir(32'h20);
      step(32'h20, 1'b0, 1'b0, "halt_exit");     redir(32'd3);
      step(32'd3, 1'b0, 1'b0, "loop3");
      step(32'd4, 1'b0, 1'b0, "loop4");
      step(32'd5, 1'b1, 1'b0, "br_hot");
      step(32'd2, 1'b0, 1'b0, "br_target");      upd(32'd5, 1'b1);
      step(32'd3, 1'b0, 1'b0, "sat_a");          upd(32'd5, 1'b1);
      step(32'd4, 1'b0, 1'b0, "sat_b");
      step(32'd5, 1'b1, 1'b0, "sat_hot");        upd(32'd5, 1'b0);
      step(32'd2, 1'b0, 1'b0, "loop2b");
      step(32'd3, 1'b0, 1'b0, "loop3b");
      step(32'd4, 1'b0, 1'b0, "loop4b");
      step(32'd5, 1'b1, 1'b0, "wt_still_taken"); upd(32'd5, 1'b0);
      step(32'd2, 1'b0, 1'b0, "same_cyc_old");
      step(32'd3, 1'b0, 1'b0, "loop3c");
      step(32'd4, 1'b0, 1'b0, "loop4c");
      step(32'd5, 1'b0, 1'b0, "wnt_old_val");    upd(32'd5, 1'b1);
      step(32'd6, 1'b0, 1'b0, "fall_through");   redir(32'd5);
      step(32'd5, 1'b1, 1'b0, "prio_setup");
      switch_program = 1'b1;
      switch_pc      = 32'h100;
      redir(32'h20);
      stall          = 1'b1;
      step(32'h100, 1'b0, 1'b0, "switch_wins");  stall = 1'b1; redir(32'h40);
      step(32'h100, 1'b0, 1'b0, "stall_hold");   redir(32'h40);
      step(32'h40, 1'b0, 1'b0, "redir_done");
      step(32'h41, 1'b0, 1'b0, "seq41");         redir(32'd5);
      step(32'd5, 1'b1, 1'b0, "redir_vs_pred");  redir(32'h30);
      step(32'h30, 1'b0, 1'b0, "redir_wins");

      // Reset asserted between edges; the coincident update must be lost.
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_inputs();
      upd(32'd5, 1'b1);
      exp_q.push_back({32'd0, 1'b0, 1'b0});
      tag_q.push_back("async_rst");

      step(32'd0, 1'b0, 1'b0, "rst_held");
      rst = 1'b1;
      step(32'd1, 1'b0, 1'b0, "rerun1");
      step(32'd2, 1'b0, 1'b0, "rerun2");
      step(32'd3, 1'b0, 1'b0, "rerun3");
      step(32'd4, 1'b0, 1'b0, "rerun4");
      step(32'd5, 1'b0, 1'b0, "bht_cleared");
      step(32'd6, 1'b0, 1'b0, "rerun6");
      switch_program = 1'b1;
      switch_pc      = 32'hFFFF_FFFF;
      step(32'hFFFF_FFFF, 1'b0, 1'b0, "pc_max");
      step(32'd0, 1'b0, 1'b0, "pc_wrapped");

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
